multimode_ff_bank: RTL and testbench

Parametrised bank of WIDTH independent single-bit storage cells. Each cell behaves as an RS, JK, D or T flip-flop, selected by a shared run-time mode input, with a common clock enable. RS-mode illegal inputs (S=R=1) are detected per channel, held in sticky flags and counted. The bank is the general-purpose successor to the single RS flip-flop and serves as the lab's reusable state-holding primitive.

---
 rtl/ff_bank_pkg.sv | 13 +
 rtl/ff_cell.sv | 60 ++++++
 rtl/multimode_ff_bank.sv | 90 +++++++++
 tb/tb_multimode_ff_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: shared definitions for the multimode flip-flop bank.
//   mode_t          2-bit run-time cell mode
//   MODE_RS/JK/D/T  mode encodings applied to every channel of the bank
package ff_bank_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RS = 2'b00;
  localparam mode_t MODE_JK = 2'b01;
  localparam mode_t MODE_D  = 2'b10;
  localparam mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/ff_cell.sv
// ff_cell: one storage channel of multimode_ff_bank.
//   clk      rising-edge clock
//   nrst     synchronous active-low reset, loads INIT
//   en       clock enable, q holds when 0
//   mode     RS / JK / D / T selection
//   a, b     S/R, J/K, D (a only), T (a only)
//   q        stored bit
//   illegal  combinational strobe: enabled RS cycle with S=R=1
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic  clk,
  input  logic  nrst,
  input  logic  en,
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  output logic  q,
  output logic  illegal
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_RS: begin
        case ({a, b})
          2'b10:   q_nxt = 1'b1;
          2'b01:   q_nxt = 1'b0;
          default: q_nxt = q;     // 00 holds; 11 is illegal and also holds
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   q_nxt = 1'b1;
          2'b01:   q_nxt = 1'b0;
          2'b11:   q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      MODE_D:  q_nxt = a;
      default: q_nxt = q ^ a;     // MODE_T
    endcase
  end

  assign illegal = en & (mode == MODE_RS) & a & b;

  // state register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      q <= INIT;
    end else if (en) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH independent RS/JK/D/T flip-flops sharing one mode,
// one clock enable and one synchronous active-low reset.
//   clk, nrst   clock and synchronous active-low reset
//   en          common clock enable
//   mode        00 RS, 01 JK, 10 D, 11 T for all channels
//   a, b        per-channel data (b ignored in D and T)
//   clr_err     clears err_vec / err_cnt (an illegal event on the same edge wins)
//   q, nq       stored state and its complement
//   err_vec     sticky per-channel RS S=R=1 flags
//   err_cnt     saturating count of cycles with at least one illegal channel
// Build option: define FF_BANK_ERR_EN to include error detection; without it
// err_vec and err_cnt are tied to zero and clr_err is ignored.
module multimode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
  parameter int               ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  mode_t                mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     nq,
  output logic [WIDTH-1:0]     err_vec,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] illegal_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .INIT (INIT[i])
    ) u_cell (
      .clk     (clk),
      .nrst    (nrst),
      .en      (en),
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .illegal (illegal_vec[i])
    );
  end

  assign nq = ~q;

`ifdef FF_BANK_ERR_EN

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic any_illegal;
  assign any_illegal = |illegal_vec;

  // error flag / counter register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_vec <= '0;
      err_cnt <= '0;
    end else if (clr_err) begin
      // a same-cycle event survives the clear as a fresh first occurrence
      err_vec <= illegal_vec;
      err_cnt <= any_illegal ? CNT_ONE : '0;
    end else begin
      err_vec <= err_vec | illegal_vec;
      if (any_illegal) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

`else

  assign err_vec = '0;
  assign err_cnt = '0;

  logic unused_err_inputs;
  assign unused_err_inputs = &{1'b0, clr_err, illegal_vec};

`endif

endmodule

// File: tb/tb_multimode_ff_bank.sv
module tb_multimode_ff_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance, INIT = A5, 8-bit counter
  logic       nrst8, en8, clr8;
  logic [1:0] mode8;
  logic [7:0] a8, b8, q8, nq8, ev8, cnt8;

  // 4-channel instance, INIT = 0, 2-bit counter
  logic       nrst4, en4, clr4;
  logic [1:0] mode4;
  logic [3:0] a4, b4, q4, nq4, ev4;
  logic [1:0] cnt4;

  multimode_ff_bank #(.WIDTH(8), .INIT(8'hA5), .ERR_CNT_W(8)) u8 (
    .clk(clk), .nrst(nrst8), .en(en8), .mode(mode8), .a(a8), .b(b8),
    .clr_err(clr8), .q(q8), .nq(nq8), .err_vec(ev8), .err_cnt(cnt8)
  );

  multimode_ff_bank #(.WIDTH(4), .INIT(4'h0), .ERR_CNT_W(2)) u4 (
    .clk(clk), .nrst(nrst4), .en(en4), .mode(mode4), .a(a4), .b(b4),
    .clr_err(clr4), .q(q4), .nq(nq4), .err_vec(ev4), .err_cnt(cnt4)
  );

  int checks = 0;
  int failures = 0;

  // reference state
  logic [7:0] mq8, mev8;
  int         mcnt8;
  logic [3:0] mq4, mev4;
  int         mcnt4;

`ifdef FF_BANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // whole-vector next-state rules written as boolean equations
  function automatic logic [31:0] model_q(input logic [31:0] q, input logic [1:0] m,
                                          input logic [31:0] a, input logic [31:0] b);
    case (m)
      2'd0:    return (q & ~(a ^ b)) | (a & ~b);
      2'd1:    return (a & ~q) | (~b & q);
      2'd2:    return a;
      default: return q ^ a;
    endcase
  endfunction

  task automatic step8(input logic n, input logic e, input logic [1:0] m,
                       input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [31:0] t;
    logic [7:0]  ill;
    nrst8 = n; en8 = e; mode8 = m; a8 = a; b8 = b; clr8 = c;
    if (!n) begin
      mq8 = 8'hA5; mev8 = '0; mcnt8 = 0;
    end else begin
      ill = (e && m == 2'd0) ? (a & b) : 8'h00;
      if (e) begin
        t = model_q({24'h0, mq8}, m, {24'h0, a}, {24'h0, b});
        mq8 = t[7:0];
      end
      if (c) begin
        mev8 = ill; mcnt8 = (ill != 0) ? 1 : 0;
      end else begin
        mev8 = mev8 | ill;
        if (ill != 0 && mcnt8 < 255) mcnt8++;
      end
    end
    @(posedge clk); #1;
    check("q8", q8, mq8);
    check("nq8", nq8, 8'(~mq8));
    check("err_vec8", ev8, ERR_EN ? mev8 : 8'h00);
    check("err_cnt8", cnt8, ERR_EN ? 8'(mcnt8) : 8'h00);
  endtask

  task automatic step4(input logic n, input logic e, input logic [1:0] m,
                       input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [31:0] t;
    logic [3:0]  ill;
    nrst4 = n; en4 = e; mode4 = m; a4 = a; b4 = b; clr4 = c;
    if (!n) begin
      mq4 = 4'h0; mev4 = '0; mcnt4 = 0;
    end else begin
      ill = (e && m == 2'd0) ? (a & b) : 4'h0;
      if (e) begin
        t = model_q({28'h0, mq4}, m, {28'h0, a}, {28'h0, b});
        mq4 = t[3:0];
      end
      if (c) begin
        mev4 = ill; mcnt4 = (ill != 0) ? 1 : 0;
      end else begin
        mev4 = mev4 | ill;
        if (ill != 0 && mcnt4 < 3) mcnt4++;
      end
    end
    @(posedge clk); #1;
    check("q4", q4, mq4);
    check("nq4", nq4, 4'(~mq4));
    check("err_vec4", ev4, ERR_EN ? mev4 : 4'h0);
    check("err_cnt4", cnt4, ERR_EN ? 2'(mcnt4) : 2'd0);
  endtask

  initial begin
    // keep the 4-channel bank in reset while the 8-channel bank is exercised
    nrst4 = 1'b0; en4 = 1'b0; clr4 = 1'b0; mode4 = 2'd0; a4 = '0; b4 = '0;

    // reset for two edges with busy inputs, then release with en=0
    step8(1'b0, 1'b1, 2'd2, 8'hFF, 8'hFF, 1'b1);
    step8(1'b0, 1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0);
    step8(1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);

    // RS
    step8(1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0);
    step8(1'b1, 1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0);
    step8(1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
    step8(1'b1, 1'b1, 2'd0, 8'hFF, 8'h01, 1'b0);

    // JK from 0F
    step8(1'b1, 1'b1, 2'd2, 8'h0F, 8'h00, 1'b0);
    step8(1'b1, 1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);
    step8(1'b1, 1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);
    step8(1'b1, 1'b1, 2'd1, 8'h00, 8'h0F, 1'b0);

    // D then T, then a disabled edge
    step8(1'b1, 1'b1, 2'd2, 8'h3C, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step8(1'b1, 1'b1, 2'd3, 8'h81, 8'h00, 1'b0);
    step8(1'b1, 1'b0, 2'd3, 8'h81, 8'h00, 1'b0);

    // disabled RS 11 records nothing; then mid-run reset
    step8(1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
    step8(1'b0, 1'b1, 2'd3, 8'hFF, 8'h00, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step8(($urandom_range(0, 29) != 0), ($urandom_range(0, 4) != 0), 2'($urandom),
            8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
    end
    // park: holds state and error flags while the other bank runs
    step8(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);

    // 4-channel bank: reset, counter saturation, clear interactions
    step4(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) step4(1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0);
    step4(1'b1, 1'b1, 2'd0, 4'h2, 4'h2, 1'b1);
    step4(1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1);
    step4(1'b1, 1'b1, 2'd0, 4'h5, 4'h0, 1'b0);
    step4(1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0);
    step4(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step4(($urandom_range(0, 29) != 0), ($urandom_range(0, 4) != 0), 2'($urandom),
            4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
    end

    // parked bank must be untouched
    check("q8_parked", q8, mq8);
    check("err_vec8_parked", ev8, ERR_EN ? mev8 : 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
